// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer.
// ILLEGAL_TRAP_EN adds the TRAP state for unknown opcodes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXECUTE  = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP   = 4'd9
`endif
  } state_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_REG   = 2'b10;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic       pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-output map for each sequencer state.
// Under ILLEGAL_TRAP_EN the TRAP state keeps every strobe low.
module mc_output_decode
  import riscv_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  input  logic   zero,
  input  logic   decode_nop,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = SRC_A_OLDPC;
        ctrl.alu_src_b  = SRC_B_IMM;
        ctrl.alu_op     = ALU_ADD;
        // Unknown opcode retires here as a NOP; PC already advanced in FETCH.
        ctrl.instr_done = decode_nop;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRC_A_REG;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = SRC_A_REG;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRC_A_REG;
        ctrl.alu_src_b  = SRC_B_REG;
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_source  = 1'b1;
        ctrl.pc_en      = zero;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: state register, next-state and retire counter.
// Define ILLEGAL_TRAP_EN to lock into TRAP on an unknown opcode instead of a NOP.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_en,
  output logic        pc_source,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        instr_done,
  output logic [3:0]  state,
  output logic [31:0] instr_count
);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  ctrl_t       dec, ctrl;
  logic        known_op, decode_nop;

  assign known_op = (opcode == OP_RTYPE) || (opcode == OP_LOAD) ||
                    (opcode == OP_STORE) || (opcode == OP_BRANCH);

`ifdef ILLEGAL_TRAP_EN
  logic trap_q, trap_d;
  assign decode_nop = 1'b0;
  assign trap_d     = trap_q | (state_q == S_TRAP);
`else
  assign decode_nop = !known_op;
`endif

  mc_output_decode u_dec (
    .state      (state_q),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .decode_nop (decode_nop),
    .ctrl       (dec)
  );

  // Gate with reset so an in-flight request drops asynchronously.
  assign ctrl = reset ? '0 : dec;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:          state_d = S_EXECUTE;
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_BRANCH:         state_d = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_R_WB;
      S_R_WB:     state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
`ifdef ILLEGAL_TRAP_EN
    if (trap_q) state_d = S_TRAP;
`endif
  end

  assign cnt_d = cnt_q + 32'(ctrl.instr_done);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) trap_q <= 1'b0;
    else       trap_q <= trap_d;
  end
`endif

  assign mem_read    = ctrl.mem_read;
  assign mem_write   = ctrl.mem_write;
  assign iord        = ctrl.iord;
  assign ir_write    = ctrl.ir_write;
  assign pc_en       = ctrl.pc_en;
  assign pc_source   = ctrl.pc_source;
  assign alu_src_a   = ctrl.alu_src_a;
  assign alu_src_b   = ctrl.alu_src_b;
  assign alu_op      = ctrl.alu_op;
  assign reg_write   = ctrl.reg_write;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign instr_done  = ctrl.instr_done;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule
